graphite_cmd_queue: RTL
=======================

// Module: graphite_cmd_queue
// PURPOSE
// - Upstream of graphite's AXI-stream command port: buffers 32-bit command words posted by the CPU at IO word 8.
// - Presents them to graphite as a compliant AXI-stream master, so the CPU no longer busy-polls tready per word.
// - Provides a status word (free slots, empty, full, idle, sticky overflow) that the IO read mux returns at word 8.
// PARAMETERS
// - DEPTH   16  FIFO entries including the output register; power of 2, >= 2.
// - DATA_W  32  command word width.
// PORTS
// - clk_cpu               in   1       CPU clock.
// - rst_n                 in   1       reset, synchronous, active-low.
// - ce_i                  in   1       system clock enable; no state changes while low.
// - wr_i                  in   1       CPU write strobe to IO word 8 (wr & ioenb & iowadr==8).
// - wdata_i               in   DATA_W  command word (outbus).
// - ovf_clr_i             in   1       clears the sticky overflow flag.
// - status_o              out  32      [31] ovf, [18] idle, [17] full, [16] empty, [15:0] free slots; other bits 0.
// - m_axis_tvalid_o       out  1       command valid to graphite.
// - m_axis_tready_i       in   1       graphite ready.
// - m_axis_tdata_o        out  DATA_W  command word to graphite.
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge):
//   - count=0, pointers=0, ovf=0, m_axis_tvalid_o=0, m_axis_tdata_o=0.
//   - status_o = {13'b0, idle=1, full=0, empty=1, free=DEPTH}.
//   - Reset mid-transfer drops every queued word; tvalid falls on the next cycle.
// - All updates are qualified by ce_i=1; with ce_i=0 all registers hold.
// - Push: ce_i & wr_i & !full. A push while full is dropped and sets ovf (sticky).
//   - A push while full is rejected even if a pop occurs in the same cycle.
// - Pop: ce_i & m_axis_tvalid_o & m_axis_tready_i.
// - Storage: memory array (DEPTH-1 entries) plus registered output stage (tdata/tvalid).
//   - count = memory occupancy + tvalid; range 0..DEPTH.
// - Latency: a word pushed into an empty queue appears on tdata with tvalid=1 on the next edge (1 cycle).
// - Output stage refill, on the same edge as a pop or whenever tvalid=0:
//   - memory non-empty: load the oldest memory word.
//   - else if pushing: load wdata_i directly (bypass).
//   - else: tvalid <= 0.
// - AXI rules:
//   - tdata is stable while tvalid & !tready.
//   - tvalid never drops without a pop, except on reset.
//   - tvalid does not depend combinationally on tready.
// - Simultaneous push and pop: count is unchanged, FIFO order is preserved.
//   - At count=1 the pushed word goes straight to the output stage.
// - Pointers are ADDR_W=$clog2(DEPTH-1 rounded up) bits and wrap modulo the memory depth.
// - full  = (count==DEPTH); empty = (count==0).
// - idle  = empty & m_axis_tready_i: graphite has drained every command.
// - free  = DEPTH-count, zero-extended to 16 bits.
// - ovf_clr_i clears ovf. If ovf_clr_i and an overflowing push occur in the same cycle, set wins.
// - status_o is combinational from registers (and tready for idle), so the CPU reads it with no added latency.
// STRUCTURE
// - graphite_pkg holds:
//   - CMD_W=32.
//   - Status bit positions: ST_OVF=31, ST_IDLE=18, ST_FULL=17, ST_EMPTY=16, ST_FREE_LSB=0, ST_FREE_W=16.
//   - IO word index GRAPHITE_IOW=8.
// - One sub-module: cmd_fifo_mem, a simple dual-port register array (1 write, 1 async read), DEPTH-1 x DATA_W.
// - Top of the block holds count, pointers, output stage and the status logic.
// TESTING
// - Reset, then push 0x11111111 with tready=1 -> tvalid=1 with tdata=0x11111111 on the next cycle; popped; status empty again.
// - tready=0, push 16 words 0..15 -> full=1, free=0.
//   - 17th push (0xDEAD) dropped, ovf=1.
//   - Then tready=1 -> graphite receives 0..15 in order, 0xDEAD absent.
// - Queue full, tready=1, wr_i=1 same cycle -> pop occurs, push rejected, ovf=1, count=15.
//   - ovf_clr_i -> status[31]=0.
// - count=1, tready=1, continuous pushes 0xA0..0xA7 -> one word per cycle out, count stays 1, no bubbles.
// - ce_i toggled 1/0 each cycle during a burst -> every state change happens only on ce_i=1 edges; no loss, no duplicates.
// - rst_n=0 asserted with 5 words queued and tvalid=1 -> next cycle tvalid=0, status = free 16, empty=1, ovf=0.

Source files
------------

// File: rtl/graphite_pkg.sv
// graphite_pkg
// Shared constants for the graphite command path: command word width,
// bit positions inside the command-queue status word, and the CPU IO word
// index at which the queue is written and its status is read back.
package graphite_pkg;

  localparam int CMD_W        = 32;

  localparam int ST_OVF       = 31;
  localparam int ST_IDLE      = 18;
  localparam int ST_FULL      = 17;
  localparam int ST_EMPTY     = 16;
  localparam int ST_FREE_LSB  = 0;
  localparam int ST_FREE_W    = 16;

  localparam int GRAPHITE_IOW = 8;

endpackage

// File: rtl/cmd_fifo_mem.sv
// cmd_fifo_mem
// Simple dual-port register array used as the backing store of the command
// queue: one synchronous write port and one asynchronous read port.
// Ports:
//   clk_cpu  in  1       clock
//   we_i     in  1       write enable (already qualified by the caller)
//   waddr_i  in  ADDR_W  write address
//   wdata_i  in  DATA_W  write data
//   raddr_i  in  ADDR_W  read address
//   rdata_o  out DATA_W  read data, combinational from the array
module cmd_fifo_mem #(
  parameter int ENTRIES = 15,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4
) (
  input  logic              clk_cpu,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [0:ENTRIES-1];

  // The array carries no reset: occupancy is tracked by the owner, so stale
  // contents are never presented.
  always_ff @(posedge clk_cpu) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/graphite_cmd_queue.sv
// graphite_cmd_queue
// Buffers command words posted by the CPU and presents them to graphite as an
// AXI-stream master. Storage is a (DEPTH-1)-entry memory plus a registered
// output stage, so the total capacity is DEPTH words. A status word reports
// free slots, empty, full, idle and a sticky overflow flag.
// Ports:
//   clk_cpu          in  1       CPU clock
//   rst_n            in  1       synchronous active-low reset
//   ce_i             in  1       clock enable; all state holds while low
//   wr_i             in  1       CPU write strobe to the command IO word
//   wdata_i          in  DATA_W  command word
//   ovf_clr_i        in  1       clears the sticky overflow flag
//   status_o         out 32      {ovf, 12'b0, idle, full, empty, free[15:0]}
//   m_axis_tvalid_o  out 1       command valid
//   m_axis_tready_i  in  1       graphite ready
//   m_axis_tdata_o   out DATA_W  command word
module graphite_cmd_queue
  import graphite_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = CMD_W
) (
  input  logic              clk_cpu,
  input  logic              rst_n,
  input  logic              ce_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              ovf_clr_i,
  output logic [31:0]       status_o,
  output logic              m_axis_tvalid_o,
  input  logic              m_axis_tready_i,
  output logic [DATA_W-1:0] m_axis_tdata_o
);

  localparam int MEM_D  = DEPTH - 1;
  localparam int ADDR_W = (MEM_D > 1) ? $clog2(MEM_D) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  mem_cnt;
  logic [CNT_W-1:0]  count;
  logic              tvalid_q;
  logic [DATA_W-1:0] tdata_q;
  logic              ovf_q;
  logic [DATA_W-1:0] mem_rdata;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic load;
  logic mem_re;
  logic mem_we;
  logic bypass;
  logic [15:0] free_slots;

  // Memory depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(MEM_D - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  assign count = mem_cnt + CNT_W'(tvalid_q);
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // A push while full is rejected even when a pop frees a slot this cycle.
  assign push = ce_i & wr_i & ~full;
  assign pop  = ce_i & tvalid_q & m_axis_tready_i;

  // The output register refills when its word leaves or when it is empty.
  // Memory always has priority so order is kept; with an empty memory a
  // concurrent push bypasses straight into the output register.
  assign load   = ce_i & (pop | ~tvalid_q);
  assign mem_re = load & (mem_cnt != '0);
  assign bypass = load & (mem_cnt == '0) & push;
  assign mem_we = push & ~bypass;

  cmd_fifo_mem #(
    .ENTRIES (MEM_D),
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W)
  ) u_mem (
    .clk_cpu (clk_cpu),
    .we_i    (mem_we),
    .waddr_i (wr_ptr),
    .wdata_i (wdata_i),
    .raddr_i (rd_ptr),
    .rdata_o (mem_rdata)
  );

  // Pointers, occupancy, output stage and the sticky overflow flag.
  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (ce_i) begin
      if (mem_we) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (mem_re) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({mem_we, mem_re})
        2'b10:   mem_cnt <= mem_cnt + CNT_W'(1);
        2'b01:   mem_cnt <= mem_cnt - CNT_W'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      if (load) begin
        if (mem_re) begin
          tdata_q  <= mem_rdata;
          tvalid_q <= 1'b1;
        end else if (bypass) begin
          tdata_q  <= wdata_i;
          tvalid_q <= 1'b1;
        end else begin
          tvalid_q <= 1'b0;
        end
      end
      // Setting wins over clearing so an overflow is never lost.
      if (wr_i && full) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign free_slots = 16'(DEPTH) - 16'(count);

  // Status is combinational so the CPU read path adds no latency.
  always_comb begin
    status_o                                  = '0;
    status_o[ST_OVF]                          = ovf_q;
    status_o[ST_IDLE]                         = empty & m_axis_tready_i;
    status_o[ST_FULL]                         = full;
    status_o[ST_EMPTY]                        = empty;
    status_o[ST_FREE_LSB +: ST_FREE_W]        = free_slots;
  end

  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tdata_o  = tdata_q;

endmodule
